apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command channel into APB transfers and returns each result on a valid/ready response channel.
- Drives the master side of the team's APB bus interface and sits directly upstream of the APB slaves.
- Handles one outstanding transfer at a time, and has a PREADY timeout so a hung slave cannot stall the requester.

Parameters:
- ADDR_WIDTH, 12, width of PADDR and req_addr
- DATA_WIDTH, 32, width of the write/read data paths
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles without PREADY before forced termination; 0 disables the timeout

Ports:
- PCLK  input  1  clock; all logic on the rising edge
- PRESET  input  1  reset, synchronous, active-high
- req_valid  input  1  command valid
- req_ready  output  1  command accepted when req_valid and req_ready are both high
- req_addr  input  ADDR_WIDTH  command address
- req_write  input  1  1 = write, 0 = read
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_slverr  output  1  slave error or timeout
- rsp_timeout  output  1  transfer ended by timeout
- PADDR  output  ADDR_WIDTH  APB address
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PWDATA  output  DATA_WIDTH  APB write data
- PRDATA  input  DATA_WIDTH  APB read data
- PREADY  input  1  APB ready
- PSLVERR  input  1  APB slave error

Behaviour:
- Reset: PRESET is sampled on the PCLK edge.
  - The FSM goes to IDLE, the timeout counter clears, and all registered outputs go to 0.
  - req_ready = (state==IDLE) && !PRESET, so it is 0 while PRESET is high.
- Reset mid-operation: any transfer in flight is dropped.
  - PSEL and PENABLE are 0 on the cycle after the reset edge.
  - No response is issued for the dropped transfer.
- IDLE: req_ready=1, PSEL=0, PENABLE=0.
  - On accept, latch addr, write and wdata into PADDR, PWRITE and PWDATA (PWDATA is loaded even for reads), then go to SETUP.
  - Request inputs are ignored when no accept occurs.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1. The counter increments each cycle PREADY=0.
  - PREADY=1: capture the result, then go to RESP with PSEL=0 and PENABLE=0.
    - rsp_rdata = PWRITE ? 0 : PRDATA.
    - rsp_slverr = PSLVERR, rsp_timeout = 0.
  - Timeout: TIMEOUT_CYCLES != 0, PREADY=0, and counter == TIMEOUT_CYCLES-1.
    - Go to RESP with rsp_rdata=0, rsp_slverr=1, rsp_timeout=1, PSEL=0, PENABLE=0.
  - PREADY and the timeout condition in the same cycle: PREADY wins.
- RESP: rsp_valid=1. rsp_* stay stable until rsp_ready=1, then go to IDLE with rsp_valid=0 on the next cycle.
- The counter clears on entry to ACCESS. Its width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit, and it never wraps.
- PADDR, PWRITE and PWDATA are constant from SETUP through the end of ACCESS, and hold their last value in IDLE and RESP.
- PSLVERR and PRDATA are sampled only in the ACCESS cycle where PREADY=1.
- Latency: accept at edge T gives SETUP in T+1 and ACCESS in T+2.
  - PREADY=1 in T+2 gives rsp_valid in T+3.
  - Minimum 4 cycles per transfer when rsp_ready is held high.
- Only one transfer is outstanding; req_ready=0 outside IDLE.

Test Plan:
- Write with zero wait: req addr=0x010, wdata=0xDEADBEEF, write=1; PREADY tied 1.
  - PSEL rises T+1, PENABLE T+2.
  - rsp_valid T+3 with rsp_rdata=0, slverr=0.
  - PADDR and PWDATA stable across T+1..T+2.
- Read with 3 wait states: read addr=0x0FC; PREADY low 3 ACCESS cycles, then high with PRDATA=0x12345678.
  - rsp_rdata=0x12345678.
  - rsp_valid on cycle T+6.
- Slave error with response backpressure: write with PSLVERR=1 at PREADY; rsp_ready held low 5 cycles.
  - rsp_slverr=1, and rsp_valid and rsp_* are held stable for all 5 cycles.
  - req_ready stays 0 throughout.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck 0.
  - ACCESS lasts exactly 4 cycles.
  - Then rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, PSEL=0.
  - Repeat with PREADY=1 on the 4th ACCESS cycle: normal response, rsp_timeout=0.
- Reset mid-ACCESS: assert PRESET for 1 cycle during ACCESS.
  - All outputs are 0 the next cycle and no rsp_valid appears.
  - A following read of 0x004 completes normally.
- Back-to-back: 3 queued reads with rsp_ready=1.
  - Each is accepted only in IDLE, 4 cycles apart.
  - Responses come back in order with the correct PRDATA.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready command channel to APB master.
// Each accepted command runs SETUP/ACCESS on the bus and returns one response.
// An ACCESS phase that waits too long on PREADY is forced to end with a timeout error.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command; req_ready high, bus idle
// SETUP  | PSEL high for one cycle with address/control stable
// ACCESS | PSEL and PENABLE high; waiting for PREADY or timeout
// RESP   | response held on rsp_* until the requester takes it
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // Counter must hold TIMEOUT_CYCLES itself; a zero timeout still needs a 1-bit counter.
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign timeout_hit = TO_EN && !PREADY && (wait_cnt == TO_LAST);
  assign req_ready   = (state == IDLE) && !PRESET;
  assign rsp_valid   = (state == RESP);

  // State register plus bus/response datapath; reset drops any transfer in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            PADDR  <= req_addr;
            PWRITE <= req_write;
            PWDATA <= req_wdata;
          end
        end
        SETUP: begin
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_slverr  <= PSLVERR;
            rsp_timeout <= 1'b0;
          end else begin
            if (timeout_hit) begin
              rsp_rdata   <= '0;
              rsp_slverr  <= 1'b1;
              rsp_timeout <= 1'b1;
            end
            // Saturate so a disabled timeout can wait forever without wrapping.
            if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and APB phase strobes.
  always_comb begin
    state_nxt = state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: scoreboarded responses, a simple APB slave model
// with configurable wait states, and cycle-level timing checks.
module tb_apb_master_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK;
  logic          PRESET;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_slverr;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  apb_master_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          tmo;
  } rsp_t;

  rsp_t sb_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rsp_seen = 0;

  // slave model configuration: slv_wait < 0 means PREADY never rises
  int            slv_wait    = 0;
  int            acc_k       = 0;
  logic [DW-1:0] slv_rdata   = '0;
  logic          slv_err     = 1'b0;
  logic          slv_by_addr = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_exp(input logic [AW-1:0] addr, input logic wr);
    rsp_t e;
    if (slv_wait < 0 || slv_wait >= TO) begin
      e.rdata  = '0;
      e.slverr = 1'b1;
      e.tmo    = 1'b1;
    end else begin
      e.rdata  = wr ? '0 : (slv_by_addr ? (slv_rdata | DW'(addr)) : slv_rdata);
      e.slverr = slv_err;
      e.tmo    = 1'b0;
    end
    sb_q.push_back(e);
  endfunction

  // One clock: score any response handshake the coming edge performs, then
  // update the slave model for the new cycle.
  task automatic tick();
    rsp_t e;
    if (rsp_valid && rsp_ready && !PRESET) begin
      rsp_seen++;
      if (sb_q.size() == 0) begin
        check_eq("rsp_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, e.rdata);
        check_eq("rsp_slverr", rsp_slverr, e.slverr);
        check_eq("rsp_timeout", rsp_timeout, e.tmo);
      end
    end
    @(posedge PCLK);
    #1;
    cyc++;
    if (PSEL && PENABLE) begin
      PREADY = (slv_wait >= 0) && (acc_k == slv_wait);
      acc_k++;
    end else begin
      PREADY = 1'b0;
      acc_k  = 0;
    end
    PRDATA  = slv_by_addr ? (slv_rdata | DW'(PADDR)) : slv_rdata;
    PSLVERR = slv_err;
  endtask

  // Present a command until accepted; returns the cycle in which the handshake was
  // visible and leaves the bench one cycle later (DUT in SETUP).
  task automatic issue(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                       output int t0);
    int n;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!req_ready) check_eq("req_accept_wait", 0, 1);
    t0 = cyc;
    push_exp(addr, wr);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int at);
    int n;
    n = 0;
    while (!rsp_valid && n < budget) begin
      tick();
      n++;
    end
    if (!rsp_valid) check_eq("rsp_wait_expired", 0, 1);
    at = cyc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int at;
    int k;
    int rv;
    int acc[3];
    logic [AW-1:0] addrs[3];
    logic [DW-1:0] hold_rdata;

    PRESET    = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // reset state
    repeat (3) tick();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_psel", PSEL, 0);
    check_eq("rst_penable", PENABLE, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_paddr", PADDR, 0);
    check_eq("rst_pwdata", PWDATA, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    PRESET = 1'b0;
    #1;
    check_eq("idle_req_ready", req_ready, 1);

    // write, zero wait
    slv_wait = 0; slv_err = 1'b0; slv_by_addr = 1'b0; slv_rdata = 32'h0BAD_0BAD;
    issue(12'h010, 1'b1, 32'hDEAD_BEEF, t0);
    check_eq("wr_setup_psel", PSEL, 1);
    check_eq("wr_setup_penable", PENABLE, 0);
    check_eq("wr_setup_paddr", PADDR, 12'h010);
    check_eq("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
    check_eq("wr_setup_pwrite", PWRITE, 1);
    check_eq("wr_setup_req_ready", req_ready, 0);
    tick();
    check_eq("wr_access_psel", PSEL, 1);
    check_eq("wr_access_penable", PENABLE, 1);
    check_eq("wr_access_paddr", PADDR, 12'h010);
    check_eq("wr_access_pwdata", PWDATA, 32'hDEAD_BEEF);
    wait_rsp(20, at);
    check_eq("wr_rsp_latency", at - t0, 3);
    check_eq("wr_rsp_psel", PSEL, 0);
    tick();
    check_eq("wr_rsp_done", rsp_valid, 0);

    // read, 3 wait states
    slv_wait = 3; slv_rdata = 32'h1234_5678;
    issue(12'h0FC, 1'b0, 32'h1111_2222, t0);
    wait_rsp(20, at);
    check_eq("rd_rsp_latency", at - t0, 6);
    check_eq("rd_rsp_rdata_direct", rsp_rdata, 32'h1234_5678);
    tick();

    // slave error with response backpressure
    slv_wait = 1; slv_err = 1'b1; slv_rdata = 32'h7777_7777;
    rsp_ready = 1'b0;
    issue(12'h020, 1'b1, 32'h0000_55AA, t0);
    wait_rsp(20, at);
    hold_rdata = rsp_rdata;
    req_valid = 1'b1; req_addr = 12'h3FF; req_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_rsp_valid", rsp_valid, 1);
      check_eq("bp_rsp_slverr", rsp_slverr, 1);
      check_eq("bp_rsp_rdata", rsp_rdata, hold_rdata);
      check_eq("bp_rsp_timeout", rsp_timeout, 0);
      check_eq("bp_req_ready", req_ready, 0);
      check_eq("bp_psel", PSEL, 0);
      tick();
    end
    req_valid = 1'b0;
    check_eq("bp_rsp_valid_end", rsp_valid, 1);
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_rsp_released", rsp_valid, 0);
    slv_err = 1'b0;

    // timeout with PREADY stuck low
    slv_wait = -1; slv_rdata = 32'hFFFF_0000;
    issue(12'h030, 1'b0, 32'h0, t0);
    tick();
    k = 0;
    while (PSEL && PENABLE && k < 20) begin
      k++;
      tick();
    end
    check_eq("tmo_access_len", k, TO);
    check_eq("tmo_rsp_valid", rsp_valid, 1);
    check_eq("tmo_psel", PSEL, 0);
    check_eq("tmo_rsp_timeout_direct", rsp_timeout, 1);
    check_eq("tmo_rsp_slverr_direct", rsp_slverr, 1);
    check_eq("tmo_rsp_rdata_direct", rsp_rdata, 0);
    tick();

    // PREADY on the last allowed ACCESS cycle wins over the timeout
    slv_wait = TO - 1; slv_rdata = 32'hCAFE_F00D;
    issue(12'h034, 1'b0, 32'h0, t0);
    tick();
    k = 0;
    while (PSEL && PENABLE && k < 20) begin
      k++;
      tick();
    end
    check_eq("late_access_len", k, TO);
    check_eq("late_rsp_timeout_direct", rsp_timeout, 0);
    tick();

    // reset in the middle of ACCESS
    slv_wait = -1;
    issue(12'h040, 1'b1, 32'hABCD_0123, t0);
    tick();
    check_eq("mid_in_access", PENABLE, 1);
    void'(sb_q.pop_back());
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    check_eq("mid_psel", PSEL, 0);
    check_eq("mid_penable", PENABLE, 0);
    check_eq("mid_rsp_valid", rsp_valid, 0);
    check_eq("mid_paddr", PADDR, 0);
    check_eq("mid_pwdata", PWDATA, 0);
    check_eq("mid_pwrite", PWRITE, 0);
    rv = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) rv++;
      tick();
    end
    check_eq("mid_no_rsp", rv, 0);
    slv_wait = 0; slv_rdata = 32'hA5A5_0004;
    issue(12'h004, 1'b0, 32'h0, t0);
    wait_rsp(20, at);
    check_eq("post_rst_latency", at - t0, 3);
    tick();

    // three back-to-back reads with addr-dependent data
    slv_wait = 0; slv_by_addr = 1'b1; slv_rdata = 32'hB000_0000;
    addrs[0] = 12'h100; addrs[1] = 12'h104; addrs[2] = 12'h108;
    req_valid = 1'b1; req_write = 1'b0;
    for (int n = 0; n < 3; n++) begin
      req_addr = addrs[n];
      k = 0;
      while (!req_ready && k < 20) begin
        tick();
        k++;
      end
      acc[n] = cyc;
      check_eq("b2b_accept_ready", req_ready, 1);
      check_eq("b2b_accept_idle_psel", PSEL, 0);
      push_exp(req_addr, 1'b0);
      tick();
    end
    req_valid = 1'b0;
    check_eq("b2b_gap_0_1", acc[1] - acc[0], 4);
    check_eq("b2b_gap_1_2", acc[2] - acc[1], 4);
    k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    tick();
    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("rsp_total", rsp_seen, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
